// File: rtl/multi_interval_timer_if.sv
// Avalon-MM slave bus bundle for multi_interval_timer: word address, select,
// active-low write strobe, 32-bit write data and registered read data.
interface multi_interval_timer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/multi_interval_timer.sv
// NUM_CH down-counting interval timers behind a 32-bit Avalon-MM slave, shared prescaler,
// per-channel IRQ. Define MULTI_TIMER_PWM_EN to add the per-channel COMPARE register and pwm_out.
module multi_interval_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESCALE     = 1,
  parameter int RESET_PERIOD = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_interval_timer_if.slave bus,
  output logic [NUM_CH-1:0]    irq,
  output logic [NUM_CH-1:0]    pwm_out
);

  localparam int AW   = $clog2(NUM_CH) + 3;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);
  localparam logic [PW-1:0]    PS_LAST    = PW'(PRESCALE - 1);

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_CONTROL = 3'd1;
  localparam logic [2:0] OFF_PERIOD  = 3'd2;
  localparam logic [2:0] OFF_SNAP    = 3'd3;
`ifdef MULTI_TIMER_PWM_EN
  localparam logic [2:0] OFF_COMPARE = 3'd4;
`endif

  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic            w_wr;
  logic [2:0]      w_off;
  logic [CH_W-1:0] w_ch;
  logic [31:0]     w_chan_rd [NUM_CH];
  logic [31:0]     w_rd_mux;
  logic [31:0]     r_rdata;

  // Free-running shared prescaler; with PRESCALE=1 every clock is a tick.
  assign w_tick = (r_presc == PS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_off = bus.address[2:0];

  generate
    if (NUM_CH > 1) begin : g_ch_sel
      assign w_ch = bus.address[AW-1:3];
    end else begin : g_ch_one
      assign w_ch = 1'b0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] r_snap;
      logic             r_to;
      logic             r_run;
      logic [3:0]       r_ctrl;
      logic             w_sel;
      logic             w_st_wr;
      logic             w_ct_wr;
      logic             w_per_wr;
      logic             w_snap_wr;
      logic             w_step;
      logic             w_zero;
      logic             w_timeout;
      logic [31:0]      w_rd;

      assign w_sel     = w_wr && (w_ch == CH_W'(i));
      assign w_st_wr   = w_sel && (w_off == OFF_STATUS);
      assign w_ct_wr   = w_sel && (w_off == OFF_CONTROL);
      assign w_per_wr  = w_sel && (w_off == OFF_PERIOD);
      assign w_snap_wr = w_sel && (w_off == OFF_SNAP);

      // A period write forces a reload, so it pre-empts any count step in that cycle.
      assign w_step    = r_run && w_tick && !w_per_wr;
      assign w_zero    = (r_cnt == '0);
      assign w_timeout = w_step && w_zero;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= RST_PERIOD;
        end else if (w_per_wr) begin
          r_cnt <= bus.writedata[CNT_W-1:0];
        end else if (w_step) begin
          r_cnt <= w_zero ? r_period : r_cnt - 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_period <= RST_PERIOD;
          r_snap   <= '0;
          r_ctrl   <= '0;
        end else begin
          if (w_per_wr) begin
            r_period <= bus.writedata[CNT_W-1:0];
          end
          if (w_snap_wr) begin
            r_snap <= r_cnt;
          end
          if (w_ct_wr) begin
            r_ctrl <= bus.writedata[3:0];
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_to <= 1'b0;
        end else if (w_st_wr) begin
          r_to <= 1'b0;
        end else if (w_timeout) begin
          r_to <= 1'b1;
        end
      end

      // START outranks every clearing source, including STOP in the same write.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_run <= 1'b0;
        end else if (w_ct_wr && bus.writedata[2]) begin
          r_run <= 1'b1;
        end else if ((w_ct_wr && bus.writedata[3]) || w_per_wr ||
                     (w_timeout && !r_ctrl[1])) begin
          r_run <= 1'b0;
        end
      end

      assign irq[i] = r_to & r_ctrl[0];

`ifdef MULTI_TIMER_PWM_EN
      logic [CNT_W-1:0] r_cmp;
      logic             r_pwm;
      logic             w_cmp_wr;

      assign w_cmp_wr = w_sel && (w_off == OFF_COMPARE);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cmp <= '0;
          r_pwm <= 1'b0;
        end else begin
          if (w_cmp_wr) begin
            r_cmp <= bus.writedata[CNT_W-1:0];
          end
          r_pwm <= r_run && (r_cnt < r_cmp);
        end
      end

      assign pwm_out[i] = r_pwm;
`else
      assign pwm_out[i] = 1'b0;
`endif

      always_comb begin
        w_rd = '0;
        case (w_off)
          OFF_STATUS:  w_rd = {30'd0, r_run, r_to};
          OFF_CONTROL: w_rd = {28'd0, r_ctrl};
          OFF_PERIOD:  w_rd = 32'(r_period);
          OFF_SNAP:    w_rd = 32'(r_snap);
`ifdef MULTI_TIMER_PWM_EN
          OFF_COMPARE: w_rd = 32'(r_cmp);
`endif
          default:     w_rd = '0;
        endcase
      end

      assign w_chan_rd[i] = w_rd;
    end
  endgenerate

  // Channel indices with no implemented channel fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ch == CH_W'(k)) begin
        w_rd_mux = w_chan_rd[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_rdata;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Bench for multi_interval_timer: two instances (4ch/32b/prescale 1 and 3ch/16b/prescale 4)
// driven by one random/directed bus stream and checked every cycle against a behavioural model.
module tb_multi_interval_timer;

  localparam int AW = 5;
`ifdef MULTI_TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address;
  logic          cs;
  logic          wn;
  logic [31:0]   wd;
  logic [3:0]    irq0, pwm0;
  logic [2:0]    irq1, pwm1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_interval_timer_if #(.AW(AW)) bus0 ();
  multi_interval_timer_if #(.AW(AW)) bus1 ();

  assign bus0.address    = address;
  assign bus0.chipselect = cs;
  assign bus0.write_n    = wn;
  assign bus0.writedata  = wd;
  assign bus1.address    = address;
  assign bus1.chipselect = cs;
  assign bus1.write_n    = wn;
  assign bus1.writedata  = wd;

  multi_interval_timer #(.NUM_CH(4), .CNT_W(32), .PRESCALE(1), .RESET_PERIOD(50000)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .irq(irq0), .pwm_out(pwm0)
  );

  multi_interval_timer #(.NUM_CH(3), .CNT_W(16), .PRESCALE(4), .RESET_PERIOD(50000)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .irq(irq1), .pwm_out(pwm1)
  );

  // Reference model state, [instance][channel].
  logic [31:0] m_cnt  [2][8];
  logic [31:0] m_per  [2][8];
  logic [31:0] m_snap [2][8];
  logic [31:0] m_cmp  [2][8];
  logic        m_to   [2][8];
  logic        m_run  [2][8];
  logic        m_pwm  [2][8];
  logic [3:0]  m_ctrl [2][8];
  logic [31:0] m_rd   [2];
  int          m_cyc  [2];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int ps(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rd[d]  = '0;
      m_cyc[d] = 0;
      for (int c = 0; c < 8; c++) begin
        m_cnt[d][c]  = 32'd50000 & mask(d);
        m_per[d][c]  = 32'd50000 & mask(d);
        m_snap[d][c] = '0;
        m_cmp[d][c]  = '0;
        m_to[d][c]   = 1'b0;
        m_run[d][c]  = 1'b0;
        m_pwm[d][c]  = 1'b0;
        m_ctrl[d][c] = '0;
      end
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input int ch, input int off);
    if (ch >= nch(d)) return 32'd0;
    case (off)
      0:       return {30'd0, m_run[d][ch], m_to[d][ch]};
      1:       return {28'd0, m_ctrl[d][ch]};
      2:       return m_per[d][ch];
      3:       return m_snap[d][ch];
      4:       return PWM ? m_cmp[d][ch] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_irq(input int d);
    logic [31:0] v = '0;
    for (int c = 0; c < nch(d); c++) v[c] = m_to[d][c] & m_ctrl[d][c][0];
    return v;
  endfunction

  function automatic logic [31:0] m_pwmv(input int d);
    logic [31:0] v = '0;
    for (int c = 0; c < nch(d); c++) v[c] = m_pwm[d][c];
    return v;
  endfunction

  // Advance the model by one clock edge using the bus inputs present at that edge.
  task automatic model_step();
    int ch, off;
    bit wr, tick, sel, stw, ctw, perw, snw, cmpw, step, tmo;
    logic [31:0] mk;
    ch  = int'(address[4:3]);
    off = int'(address[2:0]);
    wr  = cs && !wn;
    for (int d = 0; d < 2; d++) begin
      tick = ((m_cyc[d] % ps(d)) == ps(d) - 1);
      m_cyc[d]++;
      m_rd[d] = model_read(d, ch, off);
      mk = mask(d);
      for (int c = 0; c < nch(d); c++) begin
        sel  = wr && (ch == c);
        stw  = sel && (off == 0);
        ctw  = sel && (off == 1);
        perw = sel && (off == 2);
        snw  = sel && (off == 3);
        cmpw = sel && (off == 4);
        if (PWM) m_pwm[d][c] = m_run[d][c] && (m_cnt[d][c] < m_cmp[d][c]);
        step = m_run[d][c] && tick && !perw;
        tmo  = step && (m_cnt[d][c] == 0);
        if (snw) m_snap[d][c] = m_cnt[d][c];
        if (perw) begin
          m_cnt[d][c] = wd & mk;
          m_per[d][c] = wd & mk;
        end else if (step) begin
          m_cnt[d][c] = (m_cnt[d][c] == 0) ? m_per[d][c] : m_cnt[d][c] - 1;
        end
        if (stw) m_to[d][c] = 1'b0;
        else if (tmo) m_to[d][c] = 1'b1;
        if (ctw && wd[2]) m_run[d][c] = 1'b1;
        else if ((ctw && wd[3]) || perw || (tmo && !m_ctrl[d][c][1])) m_run[d][c] = 1'b0;
        if (ctw) m_ctrl[d][c] = wd[3:0];
        if (cmpw && PWM) m_cmp[d][c] = wd & mk;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rd0",  bus0.readdata, m_rd[0]);
    chk("irq0", 32'(irq0), m_irq(0));
    chk("pwm0", 32'(pwm0), m_pwmv(0));
    chk("rd1",  bus1.readdata, m_rd[1]);
    chk("irq1", 32'(irq1), m_irq(1));
    chk("pwm1", 32'(pwm1), m_pwmv(1));
  endtask

  task automatic cyc(input bit c_cs, input bit c_we, input logic [AW-1:0] a, input logic [31:0] d);
    address = a;
    cs      = c_cs;
    wn      = !c_we;
    wd      = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cyc(1'b1, 1'b1, AW'(a), d);
  endtask

  task automatic rd(input int a);
    cyc(1'b1, 1'b0, AW'(a), 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, AW'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic wait_irq(input int d, input int c, input int lim, inout int n);
    while (!((d == 0) ? irq0[c] : irq1[c]) && n < lim) begin
      idle();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, r, a, off;
    logic [31:0] v, d;
    address = '0; cs = 1'b0; wn = 1'b1; wd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_irq0", 32'(irq0), 32'd0);
    chk("rst_pwm0", 32'(pwm0), 32'd0);
    chk("rst_rd0",  bus0.readdata, 32'd0);
    reset = 1'b0;

    rd(0);  chk("rst_status", bus0.readdata, 32'd0);
    rd(2);  chk("rst_period", bus0.readdata, 32'd50000);
            chk("rst_period16", bus1.readdata, 32'd50000);
    rd(3);  chk("rst_snap", bus0.readdata, 32'd0);

    // ch1 continuous, period 9: a timeout every 10 clocks
    wr(10, 9);
    wr(9, 7);
    n = 0; wait_irq(0, 1, 100, n);
    chk("ch1_first", 32'(n), 32'd10);
    wr(8, 0);
    chk("ch1_clr", 32'(irq0[1]), 32'd0);
    n = 1; wait_irq(0, 1, 100, n);
    chk("ch1_repeat", 32'(n), 32'd10);

    // ch2 one-shot, period 3
    wr(18, 3);
    wr(17, 4);
    repeat (4) idle();
    rd(16);    chk("os_status", bus0.readdata, 32'd1);
    wr(19, 0);
    rd(19);    chk("os_hold", bus0.readdata, 32'd3);
    wr(16, 0);
    repeat (12) idle();
    rd(16);    chk("os_noto", bus0.readdata, 32'd0);

    // prescaled instance ch0, period 1: a timeout every 8 clocks
    wr(2, 1);
    wr(1, 7);
    n = 0; wait_irq(1, 0, 100, n);
    chk("ps_first_seen", 32'(irq1[0]), 32'd1);
    wr(0, 0);
    n = 1; wait_irq(1, 0, 100, n);
    chk("ps_repeat", 32'(n), 32'd8);
    wr(1, 8);
    v = m_cnt[1][0];
    repeat (10) idle();
    wr(3, 0);
    rd(3);     chk("ps_frozen", bus1.readdata, v);

    // status write landing on the same edge as a timeout
    wr(8, 0);
    n = 0; wait_irq(0, 1, 100, n);
    wr(8, 0);
    repeat (8) idle();
    wr(8, 0);
    chk("coinc_irq", 32'(irq0[1]), 32'd0);
    rd(8);     chk("coinc_status", bus0.readdata, 32'd2);

    // START|STOP together, then a period write while running
    wr(25, 12);
    rd(24);    chk("startstop", bus0.readdata, 32'd2);
               chk("ch_oob", bus1.readdata, 32'd0);
    wr(26, 5);
    wr(27, 0);
    rd(27);    chk("perw_cnt", bus0.readdata, 32'd5);
    rd(24);    chk("perw_run", bus0.readdata, 32'd0);

    // compare register and pwm duty on ch1 (period 9, still running)
    wr(12, 3);
    rd(12);
    k = 0;
    repeat (20) begin
      idle();
      if (pwm0[1]) k++;
    end
`ifdef MULTI_TIMER_PWM_EN
    chk("cmp_rd", bus0.readdata, 32'd3);
    chk("pwm_duty", 32'(k), 32'd6);
`else
    chk("cmp_rd", bus0.readdata, 32'd0);
    chk("pwm_off", 32'(k), 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 31);
      off = a % 8;
      if (r < 50) begin
        idle();
      end else if (r < 70) begin
        rd(a);
      end else begin
        if (off == 2 || off == 4) d = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 12));
        else if (off == 1) d = 32'($urandom_range(0, 15));
        else d = $urandom;
        wr(a, d);
      end
    end

    // reset mid-count while an IRQ is pending
    wr(10, 4);
    wr(9, 7);
    n = 0; wait_irq(0, 1, 100, n);
    chk("pre_rst_irq", 32'(irq0[1]), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_irq0", 32'(irq0), 32'd0);
    chk("midrst_irq1", 32'(irq1), 32'd0);
    chk("midrst_pwm0", 32'(pwm0), 32'd0);
    chk("midrst_rd0",  bus0.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    rd(10);    chk("post_rst_period", bus0.readdata, 32'd50000);
    rd(8);     chk("post_rst_status", bus0.readdata, 32'd0);
    repeat (20) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
